// File: rtl/comp2.sv
// Unsigned magnitude comparator for mastermind digit scoring, plus a small
// registered monitor that tracks equality onset and counts matching cycles.
module comp2 #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             eq_q,
  output logic             eq_rise,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Full-width unsigned compare; these flags stay live through reset.
  assign a_eq_b = (a == b);
  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q    <= 1'b0;
      eq_rise <= 1'b0;
    end else begin
      eq_q    <= a_eq_b;
      eq_rise <= a_eq_b & ~eq_q;
    end
  end

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt <= '0;
    end else if (clr) begin
      eq_cnt <= '0;
    end else if (a_eq_b && (eq_cnt != CNT_MAX)) begin
      eq_cnt <= eq_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_comp2.sv
// Self-checking bench for comp2: a per-cycle reference model plus directed
// vectors with literal expectations covering sweep, saturation, clear and reset.
module tb_comp2;

  localparam int WIDTH   = 2;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr;
  logic             a_eq_b;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             eq_q;
  logic             eq_rise;
  logic [CNT_W-1:0] eq_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit check_en = 0;

  int m_eq_q = 0;
  int m_rise = 0;
  int m_cnt  = 0;

  comp2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .clr     (clr),
    .a_eq_b  (a_eq_b),
    .a_gt_b  (a_gt_b),
    .a_lt_b  (a_lt_b),
    .eq_q    (eq_q),
    .eq_rise (eq_rise),
    .eq_cnt  (eq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ord(input int x, input int y);
    // -1, 0, +1 for x below, equal to, above y
    if (x < y) return -1;
    if (x > y) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    cmp_cnt++;
    if (actual != expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int av, input int bv, input bit cv);
    @(negedge clk);
    #2;
    a   = WIDTH'(av);
    b   = WIDTH'(bv);
    clr = cv;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the monitor must hold after each sampled edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_eq_q <= 0;
      m_rise <= 0;
      m_cnt  <= 0;
    end else begin
      m_eq_q <= (ord(int'(a), int'(b)) == 0) ? 1 : 0;
      m_rise <= (ord(int'(a), int'(b)) == 0 && m_eq_q == 0) ? 1 : 0;
      if (clr)
        m_cnt <= 0;
      else if (ord(int'(a), int'(b)) == 0 && m_cnt < CNT_MAX)
        m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_a_eq_b", int'(a_eq_b), (ord(int'(a), int'(b)) == 0) ? 1 : 0);
      checkOutput("cyc_a_gt_b", int'(a_gt_b), (ord(int'(a), int'(b)) > 0) ? 1 : 0);
      checkOutput("cyc_a_lt_b", int'(a_lt_b), (ord(int'(a), int'(b)) < 0) ? 1 : 0);
      checkOutput("cyc_eq_q", int'(eq_q), m_eq_q);
      checkOutput("cyc_eq_rise", int'(eq_rise), m_rise);
      checkOutput("cyc_eq_cnt", int'(eq_cnt), m_cnt);
    end
  end

  initial begin
    #20000;
    err_cnt++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    int eq_hits;
    rst_n = 1'b1;
    a     = '0;
    b     = 2'd1;
    clr   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_eq_q", int'(eq_q), 0);
    checkOutput("reset_eq_rise", int'(eq_rise), 0);
    checkOutput("reset_eq_cnt", int'(eq_cnt), 0);
    checkOutput("reset_lt_live", int'(a_lt_b), 1);
    check_en = 1;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Exhaustive sweep: a steps every 10, b every 40.
    eq_hits = 0;
    @(negedge clk);
    #2;
    for (int i = 0; i < 16; i++) begin
      a = WIDTH'(i % 4);
      b = WIDTH'(i / 4);
      #1;
      checkOutput("sweep_onehot", int'(a_eq_b) + int'(a_gt_b) + int'(a_lt_b), 1);
      checkOutput("sweep_gt", int'(a_gt_b), ((i % 4) > (i / 4)) ? 1 : 0);
      if (a_eq_b) eq_hits++;
      #9;
    end
    checkOutput("sweep_eq_hits", eq_hits, 4);

    a = 2'd3; b = 2'd0; #1;
    checkOutput("wrap_3_0_gt", int'(a_gt_b), 1);
    a = 2'd0; b = 2'd3; #1;
    checkOutput("wrap_0_3_lt", int'(a_lt_b), 1);
    a = 2'd3; b = 2'd3; #1;
    checkOutput("wrap_3_3_eq", int'(a_eq_b), 1);

    // Registered latency from an unequal, cleared start.
    applyStimulus(0, 1, 1'b1);
    afterEdge();
    checkOutput("lat_pre_cnt", int'(eq_cnt), 0);
    applyStimulus(2, 2, 1'b0);
    afterEdge();
    checkOutput("lat_eq_q", int'(eq_q), 1);
    checkOutput("lat_rise", int'(eq_rise), 1);
    checkOutput("lat_cnt1", int'(eq_cnt), 1);
    afterEdge();
    checkOutput("lat_rise_drop", int'(eq_rise), 0);
    checkOutput("lat_cnt2", int'(eq_cnt), 2);

    // Saturation at 7, then clear while equal.
    applyStimulus(1, 1, 1'b1);
    afterEdge();
    checkOutput("sat_clr", int'(eq_cnt), 0);
    applyStimulus(1, 1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      afterEdge();
      checkOutput("sat_count", int'(eq_cnt), (k < 7) ? k : 7);
    end
    checkOutput("sat_model_pin", m_cnt, 7);
    applyStimulus(1, 1, 1'b1);
    afterEdge();
    checkOutput("clr_wins", int'(eq_cnt), 0);
    applyStimulus(1, 1, 1'b0);
    afterEdge();
    checkOutput("clr_recount", int'(eq_cnt), 1);

    // Second rise needs an unequal sample in between.
    applyStimulus(2, 1, 1'b0);
    afterEdge();
    checkOutput("gap_eq_q", int'(eq_q), 0);
    applyStimulus(0, 0, 1'b0);
    afterEdge();
    checkOutput("rise_again", int'(eq_rise), 1);
    checkOutput("rise_again_cnt", int'(eq_cnt), 2);

    // Build count 5 then reset asynchronously between edges.
    applyStimulus(3, 3, 1'b1);
    applyStimulus(3, 3, 1'b0);
    for (int k = 0; k < 5; k++) afterEdge();
    checkOutput("pre_arst_cnt", int'(eq_cnt), 5);
    checkOutput("pre_arst_eq_q", int'(eq_q), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_eq_q", int'(eq_q), 0);
    checkOutput("arst_rise", int'(eq_rise), 0);
    checkOutput("arst_cnt", int'(eq_cnt), 0);
    checkOutput("arst_eq_live", int'(a_eq_b), 1);
    a = 2'd2; b = 2'd1; #1;
    checkOutput("arst_gt_live", int'(a_gt_b), 1);
    afterEdge();
    checkOutput("arst_hold_cnt", int'(eq_cnt), 0);

    // Release with a == b: first edge samples normally.
    @(negedge clk);
    #2;
    a = 2'd1; b = 2'd1;
    rst_n = 1'b1;
    afterEdge();
    checkOutput("rel_eq_q", int'(eq_q), 1);
    checkOutput("rel_rise", int'(eq_rise), 1);
    checkOutput("rel_cnt", int'(eq_cnt), 1);
    afterEdge();
    checkOutput("rel_rise_drop", int'(eq_rise), 0);

    @(negedge clk);
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
